imm_ext_pipe: RTL and testbench

// - Parametrised, pipelined immediate generator for the PipelineCPU decode/execute boundary.
// - Extends an IN_W-bit instruction immediate to OUT_W bits in one of five modes (zero, sign, LUI, branch-offset, shamt).
// - Carries a sideband tag, uses valid/ready handshaking, accepts one immediate per cycle and supports pipeline flush.
// - Replaces the LuiOp/SignedOp combinational extender and the separate branch-shift path with one stallable unit.

---
 rtl/imm_ext_pkg.sv | 14 +
 rtl/imm_ext_core.sv | 34 +++
 rtl/imm_ext_pipe.sv | 135 +++++++++++++
 tb/tb_imm_ext_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the pipelined immediate extender: mode encoding and widths.
package imm_ext_pkg;

    localparam int IMM_MODE_W = 3;

    typedef enum logic [IMM_MODE_W-1:0] {
        ZERO   = 3'd0,
        SIGN   = 3'd1,
        LUI    = 3'd2,
        BRANCH = 3'd3,
        SHAMT  = 3'd4
    } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: (imm, mode) -> (ext, err).
// Reserved modes return zero with err set.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 32,
    parameter int BR_SHIFT  = 2,
    parameter int SHAMT_LSB = 6
) (
    input  logic [IN_W-1:0]       imm,
    input  logic [IMM_MODE_W-1:0] mode,
    output logic [OUT_W-1:0]      ext,
    output logic                  err
);

    logic [OUT_W-1:0] sext;

    assign sext = OUT_W'($signed(imm));

    always_comb begin
        ext = '0;
        err = 1'b0;
        case (mode)
            ZERO:    ext = OUT_W'(imm);
            SIGN:    ext = sext;
            LUI:     ext = OUT_W'(imm) << (OUT_W - IN_W);
            BRANCH:  ext = sext << BR_SHIFT;
            SHAMT:   ext = OUT_W'(imm[SHAMT_LSB+4 -: 5]);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Stallable 1- or 2-stage immediate extender with valid/ready handshake, tag sideband and flush.
// Ready is resolved back-to-front combinationally so a full pipe still accepts one entry per cycle.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 32,
    parameter int BR_SHIFT  = 2,
    parameter int SHAMT_LSB = 6,
    parameter int TAG_W     = 5,
    parameter int STAGES    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_ext,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_err
);

    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("imm_ext_pipe: STAGES must be 1 or 2");
    end
    if (OUT_W < IN_W + BR_SHIFT || SHAMT_LSB + 5 > IN_W) begin : g_bad_widths
        $error("imm_ext_pipe: inconsistent width parameters");
    end

    logic                  s1_vld_q,  s1_vld_d;
    logic [IN_W-1:0]       s1_imm_q,  s1_imm_d;
    logic [IMM_MODE_W-1:0] s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0]      s1_tag_q,  s1_tag_d;
    logic                  s1_dn_rdy;
    logic [OUT_W-1:0]      s1_ext;
    logic                  s1_err;

    assign in_ready = !s1_vld_q || s1_dn_rdy;

    // Data only loads on an actual transfer so a stalled entry never changes.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_imm_d  = s1_imm_q;
        s1_mode_d = s1_mode_q;
        s1_tag_d  = s1_tag_q;
        if (in_ready) s1_vld_d = in_valid;
        if (in_valid && in_ready) begin
            s1_imm_d  = in_imm;
            s1_mode_d = in_mode;
            s1_tag_d  = in_tag;
        end
        if (flush) s1_vld_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_imm_q  <= '0;
            s1_mode_q <= '0;
            s1_tag_q  <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_imm_q  <= s1_imm_d;
            s1_mode_q <= s1_mode_d;
            s1_tag_q  <= s1_tag_d;
        end
    end

    imm_ext_core #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .BR_SHIFT  (BR_SHIFT),
        .SHAMT_LSB (SHAMT_LSB)
    ) u_core (
        .imm  (s1_imm_q),
        .mode (s1_mode_q),
        .ext  (s1_ext),
        .err  (s1_err)
    );

    if (STAGES == 2) begin : g_s2
        logic             s2_vld_q, s2_vld_d;
        logic [OUT_W-1:0] s2_ext_q, s2_ext_d;
        logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
        logic             s2_err_q, s2_err_d;

        assign s1_dn_rdy = !s2_vld_q || out_ready;

        always_comb begin
            s2_vld_d = s2_vld_q;
            s2_ext_d = s2_ext_q;
            s2_tag_d = s2_tag_q;
            s2_err_d = s2_err_q;
            if (s1_dn_rdy) s2_vld_d = s1_vld_q;
            if (s1_vld_q && s1_dn_rdy) begin
                s2_ext_d = s1_ext;
                s2_tag_d = s1_tag_q;
                s2_err_d = s1_err;
            end
            if (flush) s2_vld_d = 1'b0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld_q <= 1'b0;
                s2_ext_q <= '0;
                s2_tag_q <= '0;
                s2_err_q <= 1'b0;
            end else begin
                s2_vld_q <= s2_vld_d;
                s2_ext_q <= s2_ext_d;
                s2_tag_q <= s2_tag_d;
                s2_err_q <= s2_err_d;
            end
        end

        assign out_valid = s2_vld_q;
        assign out_ext   = s2_ext_q;
        assign out_tag   = s2_tag_q;
        assign out_err   = s2_err_q;
    end else begin : g_s1
        // Reset clears s1 to mode ZERO / imm 0, so the outputs read 0 during reset.
        assign s1_dn_rdy = out_ready;
        assign out_valid = s1_vld_q;
        assign out_ext   = s1_ext;
        assign out_tag   = s1_tag_q;
        assign out_err   = s1_err;
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: modes, latency, streaming, backpressure, flush and reset.
module tb_imm_ext_pipe;

    localparam int STAGES = 2;

    typedef struct packed {
        logic [31:0] ext;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_ext;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    logic        obs_in_rdy, obs_out_vld, obs_in_fire, obs_out_fire, obs_err;
    logic [31:0] obs_ext;
    logic [4:0]  obs_tag;

    logic [15:0] mv_imm  [6] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h0140, 16'h1234};
    logic [2:0]  mv_mode [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [4:0]  mv_tag  [6] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h1A};
    logic [31:0] mv_ext  [6] = '{32'h00008001, 32'hFFFF8001, 32'h80010000,
                                 32'hFFFFFFFC, 32'h00000005, 32'h00000000};
    logic        mv_err  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    imm_ext_pipe #(
        .IN_W(16), .OUT_W(32), .BR_SHIFT(2), .SHAMT_LSB(6), .TAG_W(5), .STAGES(STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ext(out_ext), .out_tag(out_tag), .out_err(out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [15:0] imm, input logic [2:0] mode,
                                   input logic [4:0] tag);
        exp_t e;
        e.tag = tag;
        e.err = 1'b0;
        case (mode)
            3'd0:    e.ext = {16'h0000, imm};
            3'd1:    e.ext = {{16{imm[15]}}, imm};
            3'd2:    e.ext = {imm, 16'h0000};
            3'd3:    e.ext = {{14{imm[15]}}, imm, 2'b00};
            3'd4:    e.ext = {27'd0, imm[10:6]};
            default: begin e.ext = 32'd0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // One clock of stimulus; records what the DUT showed just before the edge.
    task automatic step(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                        input logic [4:0] tag, input logic ordy, input logic fl);
        in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        obs_in_rdy   = in_ready;
        obs_out_vld  = out_valid;
        obs_in_fire  = v && in_ready && !fl;
        obs_out_fire = out_valid && ordy;
        obs_ext = out_ext; obs_tag = out_tag; obs_err = out_err;
        if (obs_in_fire) sb.push_back(model(imm, mode, tag));
        @(posedge clk);
        #1;
        if (fl) sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_mode = '0; in_tag = '0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_ext, out_tag, out_err} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs: got vld=%b ext=%h tag=%h err=%b, want all 0",
                     out_valid, out_ext, out_tag, out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_modes();
        exp_t e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mv_imm[i], mv_mode[i], mv_tag[i], 1'b1, 1'b0);
            checks++;
            if (obs_in_fire !== 1'b1) begin
                failures++;
                $display("FAIL modes_accept[%0d]: in_ready=%b want 1", i, obs_in_rdy);
            end
            lat = 0;
            for (int c = 1; c <= 6 && lat == 0; c++) begin
                step(1'b0, 16'h0, 3'd0, 5'h0, 1'b1, 1'b0);
                if (obs_out_fire) begin
                    lat = c;
                    if (sb.size() > 0) e = sb.pop_front();
                    checks++;
                    if ({obs_ext, obs_tag, obs_err} !== {mv_ext[i], mv_tag[i], mv_err[i]}) begin
                        failures++;
                        $display("FAIL mode_vec[%0d]: got ext=%h tag=%h err=%b want ext=%h tag=%h err=%b",
                                 i, obs_ext, obs_tag, obs_err, mv_ext[i], mv_tag[i], mv_err[i]);
                    end
                end
            end
            checks++;
            if (lat != STAGES) begin
                failures++;
                $display("FAIL mode_latency[%0d]: got %0d edges want %0d", i, lat, STAGES);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] imm [8];
        logic [2:0]  mode [8];
        exp_t e;
        int sent = 0, got = 0, first = -1, last = -1, acc8 = 0;
        for (int i = 0; i < 8; i++) begin
            imm[i]  = 16'($urandom);
            mode[i] = 3'($urandom_range(0, 7));
        end
        for (int s = 0; s < 40 && got < 8; s++) begin
            if (sent < 8) step(1'b1, imm[sent], mode[sent], 5'(sent + 8), 1'b1, 1'b0);
            else          step(1'b0, 16'h0, 3'd0, 5'h0, 1'b1, 1'b0);
            if (obs_in_fire) begin
                sent++;
                if (s < 8) acc8++;
            end
            if (obs_out_fire) begin
                if (first < 0) first = s;
                last = s;
                got++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: tag=%h appeared, nothing expected", obs_tag);
                end else begin
                    e = sb.pop_front();
                    if ({obs_ext, obs_tag, obs_err} !== e) begin
                        failures++;
                        $display("FAIL b2b_data: got ext=%h tag=%h err=%b want ext=%h tag=%h err=%b",
                                 obs_ext, obs_tag, obs_err, e.ext, e.tag, e.err);
                    end
                end
            end
        end
        checks++;
        if (acc8 != 8 || got != 8 || last - first != 7 || first != STAGES) begin
            failures++;
            $display("FAIL b2b_throughput: accepts=%0d outs=%0d first=%0d span=%0d want 8 8 %0d 7",
                     acc8, got, first, last - first, STAGES);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] imm [10];
        exp_t e;
        logic [31:0] hold_ext;
        logic        ordy;
        int sent = 0, got = 0;
        for (int i = 0; i < 10; i++) imm[i] = 16'($urandom);
        hold_ext = '0;
        for (int s = 0; s < 60 && got < 10; s++) begin
            ordy = !(s >= 3 && s <= 6);
            if (sent < 10) step(1'b1, imm[sent], 3'(sent % 5), 5'(sent), ordy, 1'b0);
            else           step(1'b0, 16'h0, 3'd0, 5'h0, ordy, 1'b0);
            if (obs_in_fire) sent++;
            if (s == 3) hold_ext = obs_ext;
            if (s >= 4 && s <= 6) begin
                checks++;
                if (obs_out_vld !== 1'b1 || obs_ext !== hold_ext) begin
                    failures++;
                    $display("FAIL bp_stable[%0d]: vld=%b ext=%h want vld=1 ext=%h",
                             s, obs_out_vld, obs_ext, hold_ext);
                end
            end
            if (s == 5) begin
                checks++;
                if (obs_in_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready: got %b want 0 with full pipe", obs_in_rdy);
                end
            end
            if (obs_out_fire) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL bp_dup: tag=%h appeared, nothing expected", obs_tag);
                end else begin
                    e = sb.pop_front();
                    if ({obs_ext, obs_tag, obs_err} !== e) begin
                        failures++;
                        $display("FAIL bp_data: got ext=%h tag=%h err=%b want ext=%h tag=%h err=%b",
                                 obs_ext, obs_tag, obs_err, e.ext, e.tag, e.err);
                    end
                end
            end
        end
        checks++;
        if (got != 10 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_count: outputs=%0d pending=%0d want 10 and 0", got, sb.size());
        end
    endtask

    task automatic test_flush();
        int spurious = 0;
        int fills = 0;
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 16'h1111, 3'd1, 5'(5'h1D + fills), 1'b0, 1'b0);
            if (obs_in_fire) fills++;
            if (!obs_in_rdy) break;
        end
        checks++;
        if (fills != STAGES || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_fill: accepted=%0d vld=%b want %0d and 1", fills, out_valid, STAGES);
        end
        step(1'b1, 16'h2222, 3'd0, 5'h1F, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_out_valid: got %b want 0", out_valid);
        end
        // Flush on an empty pipe while the input is being offered: entry must be dropped.
        step(1'b1, 16'h3333, 3'd0, 5'h1C, 1'b1, 1'b1);
        checks++;
        if (obs_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL flush_in_ready: got %b want 1", obs_in_rdy);
        end
        for (int s = 0; s < 6; s++) begin
            step(1'b0, 16'h0, 3'd0, 5'h0, 1'b1, 1'b0);
            if (obs_out_vld) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL flush_leak: got %0d outputs after flush, want 0", spurious);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat = 0;
        step(1'b1, 16'h4444, 3'd0, 5'h11, 1'b0, 1'b0);
        step(1'b1, 16'h5555, 3'd0, 5'h12, 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_prefill: out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ext !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_async: vld=%b ext=%h want 0 0", out_valid, out_ext);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_rel_in_ready: got %b want 1", in_ready);
        end
        step(1'b1, 16'hFF80, 3'd1, 5'h07, 1'b1, 1'b0);
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            step(1'b0, 16'h0, 3'd0, 5'h0, 1'b1, 1'b0);
            if (obs_out_fire) begin
                lat = c;
                checks++;
                e = (sb.size() > 0) ? sb.pop_front() : exp_t'('0);
                if ({obs_ext, obs_tag, obs_err} !== {32'hFFFFFF80, 5'h07, 1'b0}) begin
                    failures++;
                    $display("FAIL rst_rel_data: got ext=%h tag=%h err=%b want FFFFFF80 07 0",
                             obs_ext, obs_tag, obs_err);
                end
            end
        end
        checks++;
        if (lat != STAGES || sb.size() != 0) begin
            failures++;
            $display("FAIL rst_rel_latency: got %0d pending=%0d want %0d and 0", lat, sb.size(), STAGES);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, limit 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
